// File: rtl/ysyx_24090003_pkg.sv
// Shared constants and helpers for the register-file writeback path.
package ysyx_24090003_pkg;

   localparam int NR_REG = 32;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   // Writeback source; also the bit position in the arbiter req/gnt vectors.
   typedef enum logic {
      WB_SRC_EXU = 1'b0,
      WB_SRC_LSU = 1'b1
   } wb_src_e;

   // A register index is live when it names a real, writable register (not x0, in range).
   function automatic logic rd_live(input logic [ADDR_W-1:0] rd);
      return (rd != '0) && (int'(rd) < NR_REG);
   endfunction

endpackage

// File: rtl/ysyx_24090003_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on contention the
// pointer side wins and the pointer moves to the other side.
module ysyx_24090003_rr_arb2
   import ysyx_24090003_pkg::*;
(
   input  logic       cpu_clk,
   input  logic       cpu_rs,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   wb_src_e ptr_q;

   // Combinational grant from the request pair and the priority pointer.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt[ptr_q] = 1'b1;
         default: gnt = 2'b00;
      endcase
   end

   // Pointer only advances on a contested grant so a lone requester never loses its turn.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rs) begin
         ptr_q <= WB_SRC_EXU;
      end else if (&req) begin
         ptr_q <= (ptr_q == WB_SRC_EXU) ? WB_SRC_LSU : WB_SRC_EXU;
      end
   end

endmodule

// File: rtl/ysyx_24090003_rf_wb_ctrl.sv
// Register-file write-port controller with a busy scoreboard for RAW/WAW hazards.
module ysyx_24090003_rf_wb_ctrl
   import ysyx_24090003_pkg::*;
(
   input  logic              cpu_clk,
   input  logic              cpu_rs,
   input  logic              flush,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   output logic              issue_ready,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   output logic              rs1_busy,
   output logic              rs2_busy,
   input  logic              exu_wb_valid,
   input  logic [ADDR_W-1:0] exu_wb_rd,
   input  logic [DATA_W-1:0] exu_wb_data,
   output logic              exu_wb_ready,
   input  logic              lsu_wb_valid,
   input  logic [ADDR_W-1:0] lsu_wb_rd,
   input  logic [DATA_W-1:0] lsu_wb_data,
   output logic              lsu_wb_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              sb_err
);

   logic [NR_REG-1:0] busy_q;
   logic [NR_REG-1:0] set_mask;
   logic [NR_REG-1:0] clr_mask;
   logic [1:0]        wb_req;
   logic [1:0]        wb_gnt;
   logic [ADDR_W-1:0] wb_rd;
   logic              err_nxt;

   assign wb_req = {lsu_wb_valid, exu_wb_valid};

   ysyx_24090003_rr_arb2 u_arb (
      .cpu_clk (cpu_clk),
      .cpu_rs  (cpu_rs),
      .req     (wb_req),
      .gnt     (wb_gnt)
   );

   assign exu_wb_ready = wb_gnt[WB_SRC_EXU];
   assign lsu_wb_ready = wb_gnt[WB_SRC_LSU];

   assign wb_rd    = wb_gnt[WB_SRC_LSU] ? lsu_wb_rd : exu_wb_rd;
   assign rf_waddr = wb_rd;
   assign rf_wdata = wb_gnt[WB_SRC_LSU] ? lsu_wb_data : exu_wb_data;
   assign rf_we    = (|wb_gnt) && rd_live(wb_rd);

   // Hazard view uses the busy state before this cycle's writeback clears it (no bypass).
   assign issue_ready = issue_valid && !(rd_live(issue_rd) && busy_q[issue_rd]) && !flush;
   assign rs1_busy    = rd_live(rs1) && busy_q[rs1];
   assign rs2_busy    = rd_live(rs2) && busy_q[rs2];

   // Per-cycle set/clear masks and the write-to-idle-register error condition.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (rf_we) begin
         clr_mask[wb_rd] = 1'b1;
      end
      if (issue_ready && rd_live(issue_rd)) begin
         set_mask[issue_rd] = 1'b1;
      end
      err_nxt = rf_we && !busy_q[wb_rd] && !flush;
   end

   // Scoreboard update: flush wipes everything, otherwise clear then set.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rs) begin
         busy_q <= '0;
         sb_err <= 1'b0;
      end else begin
         sb_err <= err_nxt;
         if (flush) begin
            busy_q <= '0;
         end else begin
            busy_q <= (busy_q & ~clr_mask) | set_mask;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_24090003_rf_wb_ctrl.sv
// Randomised bench for the writeback controller with a per-register reference model.
module tb_ysyx_24090003_rf_wb_ctrl;

   logic        cpu_clk = 1'b0;
   logic        cpu_rs = 1'b1;
   logic        flush = 1'b0;
   logic        issue_valid = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic        issue_ready;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic        rs1_busy, rs2_busy;
   logic        exu_wb_valid = 1'b0;
   logic [4:0]  exu_wb_rd = '0;
   logic [31:0] exu_wb_data = '0;
   logic        exu_wb_ready;
   logic        lsu_wb_valid = 1'b0;
   logic [4:0]  lsu_wb_rd = '0;
   logic [31:0] lsu_wb_data = '0;
   logic        lsu_wb_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        sb_err;

   always #5 cpu_clk = ~cpu_clk;

   ysyx_24090003_rf_wb_ctrl dut (
      .cpu_clk      (cpu_clk),
      .cpu_rs       (cpu_rs),
      .flush        (flush),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_ready  (issue_ready),
      .rs1          (rs1),
      .rs2          (rs2),
      .rs1_busy     (rs1_busy),
      .rs2_busy     (rs2_busy),
      .exu_wb_valid (exu_wb_valid),
      .exu_wb_rd    (exu_wb_rd),
      .exu_wb_data  (exu_wb_data),
      .exu_wb_ready (exu_wb_ready),
      .lsu_wb_valid (lsu_wb_valid),
      .lsu_wb_rd    (lsu_wb_rd),
      .lsu_wb_data  (lsu_wb_data),
      .lsu_wb_ready (lsu_wb_ready),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .sb_err       (sb_err)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // reference model: set of pending destinations, whose turn it is on contention, error flag
   bit [31:0] m_busy = '0;
   bit        m_lsu_turn = 1'b0;
   bit        m_err = 1'b0;
   bit        m_known = 1'b0;
   bit        m_ge, m_gl;

   logic o_ir, o_b1, o_b2, o_er, o_lr, o_we, o_err;
   logic [4:0]  o_wa;
   logic [31:0] o_wd;

   task automatic step(input bit rs, input bit fl, input bit iv, input bit [4:0] ird,
                       input bit [4:0] r1, input bit [4:0] r2,
                       input bit ev, input bit [4:0] erd, input bit [31:0] ed,
                       input bit lv, input bit [4:0] lrd, input bit [31:0] ld);
      bit [4:0]  wrd;
      bit [31:0] wd;
      bit        we, ir;
      @(negedge cpu_clk);
      cpu_rs = rs; flush = fl; issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
      exu_wb_valid = ev; exu_wb_rd = erd; exu_wb_data = ed;
      lsu_wb_valid = lv; lsu_wb_rd = lrd; lsu_wb_data = ld;
      #1;
      m_ge = ev && !(lv && m_lsu_turn);
      m_gl = lv && !(ev && !m_lsu_turn);
      wrd  = m_gl ? lrd : erd;
      wd   = m_gl ? ld : ed;
      we   = (m_ge || m_gl) && (wrd != 0);
      ir   = iv && !m_busy[ird] && !fl;
      o_ir = issue_ready; o_b1 = rs1_busy; o_b2 = rs2_busy; o_er = exu_wb_ready;
      o_lr = lsu_wb_ready; o_we = rf_we; o_wa = rf_waddr; o_wd = rf_wdata; o_err = sb_err;
      if (m_known && !rs) begin
         chk("sb_err", 32'(o_err), 32'(m_err));
         chk("issue_ready", 32'(o_ir), 32'(ir));
         chk("rs1_busy", 32'(o_b1), 32'(m_busy[r1]));
         chk("rs2_busy", 32'(o_b2), 32'(m_busy[r2]));
         chk("exu_ready", 32'(o_er), 32'(m_ge));
         chk("lsu_ready", 32'(o_lr), 32'(m_gl));
         chk("rf_we", 32'(o_we), 32'(we));
         if (we) begin
            chk("rf_waddr", 32'(o_wa), 32'(wrd));
            chk("rf_wdata", o_wd, wd);
         end
      end
      if (rs) begin
         m_busy = '0; m_lsu_turn = 1'b0; m_err = 1'b0; m_known = 1'b1;
      end else begin
         m_err = we && !m_busy[wrd] && !fl;
         if (fl) begin
            m_busy = '0;
         end else begin
            if (we) m_busy[wrd] = 1'b0;
            if (ir && ird != 0) m_busy[ird] = 1'b1;
         end
         if (ev && lv) m_lsu_turn = !m_lsu_turn;
      end
   endtask

   function automatic bit [4:0] pick_rd();
      bit [4:0] r;
      if (m_busy != 0 && $urandom_range(3) != 0) begin
         for (int k = 0; k < 64; k++) begin
            r = 5'($urandom);
            if (m_busy[r]) return r;
         end
      end
      return 5'($urandom);
   endfunction

   bit        pe_v, pl_v, rrs, rfl;
   bit [4:0]  pe_rd, pl_rd;
   bit [31:0] pe_d, pl_d;

   initial begin
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_sb_err", 32'(o_err), 0);
      chk("rst_rf_we", 32'(o_we), 0);

      // issue, hazard visible, writeback clears it
      step(0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t1_issue", 32'(o_ir), 1);
      step(0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      chk("t1_rs1_busy", 32'(o_b1), 1);
      step(0, 0, 0, 0, 5, 0, 1, 5, 32'h1234, 0, 0, 0);
      chk("t1_we", 32'(o_we), 1);
      chk("t1_waddr", 32'(o_wa), 5);
      chk("t1_wdata", o_wd, 32'h1234);
      step(0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      chk("t1_rs1_clear", 32'(o_b1), 0);

      // contention alternates, nothing dropped
      step(0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 7, 32'h77);
      chk("t2_c1_waddr", 32'(o_wa), 3);
      chk("t2_c1_lsu_wait", 32'(o_lr), 0);
      step(0, 0, 0, 0, 0, 0, 1, 11, 32'hbb, 1, 7, 32'h77);
      chk("t2_c2_waddr", 32'(o_wa), 7);
      chk("t2_c2_exu_wait", 32'(o_er), 0);
      step(0, 0, 0, 0, 0, 0, 1, 11, 32'hbb, 0, 0, 0);
      chk("t2_c3_waddr", 32'(o_wa), 11);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t2_no_err", 32'(o_err), 0);

      // issue stalls until the cycle after the clearing writeback
      step(0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t3_stall", 32'(o_ir), 0);
      step(0, 0, 1, 9, 0, 0, 1, 9, 32'h99, 0, 0, 0);
      chk("t3_stall_same_cycle", 32'(o_ir), 0);
      step(0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t3_go", 32'(o_ir), 1);
      step(0, 0, 0, 0, 0, 0, 1, 9, 32'h9, 0, 0, 0);

      // x0 never busy, never written
      step(0, 0, 1, 0, 0, 0, 1, 0, 32'hdead, 0, 0, 0);
      chk("t4_issue", 32'(o_ir), 1);
      chk("t4_exu_ready", 32'(o_er), 1);
      chk("t4_we", 32'(o_we), 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t4_err", 32'(o_err), 0);

      // writeback to an idle register: write performed, one-cycle error
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h44);
      chk("t5_we", 32'(o_we), 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t5_err", 32'(o_err), 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t5_err_gone", 32'(o_err), 0);

      // flush, then reset during contention
      step(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t6_flush_issue", 32'(o_ir), 0);
      step(0, 0, 0, 0, 2, 6, 0, 0, 0, 0, 0, 0);
      chk("t6_rs1_flushed", 32'(o_b1), 0);
      chk("t6_rs2_flushed", 32'(o_b2), 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 2);
      chk("t6_pre_exu", 32'(o_er), 1);
      step(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 2);
      step(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 2);
      chk("t6_post_rst_exu", 32'(o_er), 1);
      chk("t6_post_rst_lsu", 32'(o_lr), 0);

      // random traffic with requesters holding until granted
      pe_v = 0; pl_v = 0;
      for (int i = 0; i < 4000; i++) begin
         rrs = ($urandom_range(199) == 0);
         rfl = ($urandom_range(24) == 0);
         if (!pe_v && $urandom_range(1) == 1) begin
            pe_v = 1; pe_rd = pick_rd(); pe_d = $urandom;
         end
         if (!pl_v && $urandom_range(1) == 1) begin
            pl_v = 1; pl_rd = pick_rd(); pl_d = $urandom;
         end
         step(rrs, rfl, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              pe_v, pe_rd, pe_d, pl_v, pl_rd, pl_d);
         if (rrs) begin
            pe_v = 0; pl_v = 0;
         end else begin
            if (m_ge) pe_v = 0;
            if (m_gl) pl_v = 0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
